// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over UART 8N1 and writes it into
// instruction memory while holding the core in reset. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int MAX_WORDS    = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        rx_state_dbg,
  output logic [2:0]        ld_state_dbg
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_WORD, LD_CHECK, LD_DONE, LD_ERROR} ld_state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_t AFTER_LOAD = LD_CHECK;
`else
  localparam ld_state_t AFTER_LOAD = LD_DONE;
`endif

  rx_state_t        rx_state, rx_next;
  ld_state_t        ld_state, ld_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;
  logic             cnt_half, cnt_last;
  logic [7:0]       len_lo;
  logic [15:0]      len, rx_len;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic             last_word, word_end, started;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign cnt_half     = (clk_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign cnt_last     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign rx_len       = {rx_shift, len_lo};
  assign last_word    = (16'(imem_addr) == len - 16'd1);
  assign word_end     = (ld_state == LD_WORD) && byte_valid && (byte_idx == 2'd3);
  assign busy         = started && (ld_state != LD_DONE) && (ld_state != LD_ERROR);
  assign rx_state_dbg = rx_state;
  assign ld_state_dbg = ld_state;

  // byte_valid/frame_err are single-cycle strobes raised when the stop bit is sampled.
  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (cnt_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_last && bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (cnt_last) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      if (rx_state == RX_IDLE || rx_next != rx_state || cnt_last) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START) bit_cnt <= '0;
      else if (rx_state == RX_DATA && cnt_last) bit_cnt <= bit_cnt + 1'b1;
      if (rx_state == RX_DATA && cnt_last) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_LEN0: if (byte_valid) ld_next = LD_LEN1;
      LD_LEN1: begin
        if (byte_valid) begin
          if (rx_len == 16'd0) ld_next = AFTER_LOAD;
          else if (rx_len > 16'(MAX_WORDS)) ld_next = LD_ERROR;
          else ld_next = LD_WORD;
        end
      end
      LD_WORD: if (word_end && last_word) ld_next = AFTER_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHECK: if (byte_valid) ld_next = (rx_shift == csum) ? LD_DONE : LD_ERROR;
`endif
      LD_DONE, LD_ERROR: ld_next = ld_state;
      default: ld_next = LD_ERROR;
    endcase
    if (frame_err && ld_state != LD_DONE && ld_state != LD_ERROR) ld_next = LD_ERROR;
  end

  // The address advances after the write pulse, except after the last word so it stays at N-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state   <= LD_LEN0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      started    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      ld_state   <= ld_next;
      imem_we    <= word_end;
      cpu_reset  <= (ld_state != LD_DONE);
      load_done  <= (ld_state == LD_DONE);
      load_error <= (ld_state == LD_ERROR);
      if (rx_state == RX_START) started <= 1'b1;
      if (ld_state == LD_LEN0 && byte_valid) len_lo <= rx_shift;
      if (ld_state == LD_LEN1 && byte_valid) len <= rx_len;
      if (ld_state == LD_WORD && byte_valid) begin
        byte_idx <= byte_idx + 1'b1;
        word_buf <= {rx_shift, word_buf[23:8]};
      end
      if (word_end) imem_wdata <= {rx_shift, word_buf};
      if (imem_we && ld_state == LD_WORD) imem_addr <= imem_addr + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (byte_valid && (ld_state == LD_LEN0 || ld_state == LD_LEN1 || ld_state == LD_WORD))
        csum <= csum ^ rx_shift;
`endif
    end
  end
endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table of directed images plus hand sequences for
// glitch rejection, mid-load reset and completion timing.
module tb_imem_uart_loader;
  localparam int CPB       = 8;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;
  localparam int W         = ADDR_W + 32;

  logic              clock, reset, uart_rx;
  logic              imem_we, cpu_reset, busy, load_done, load_error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [1:0]        rx_state_dbg;
  logic [2:0]        ld_state_dbg;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .load_done(load_done), .load_error(load_error),
    .rx_state_dbg(rx_state_dbg), .ld_state_dbg(ld_state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int rel_cyc = 0;
  logic done_prev = 1'b0;
  logic rst_prev = 1'b1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // scoreboard: every observed write must match the head of exp_q
  always @(negedge clock) begin
    if (reset && imem_we) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", 64'({imem_addr, imem_wdata}), 64'(mon_e));
      end
    end
    if (load_done && !done_prev) done_cyc = cyc;
    if (!cpu_reset && rst_prev) rel_cyc = cyc;
    done_prev = load_done;
    rst_prev  = cpu_reset;
  end

  // driver tasks
  task automatic do_reset();
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_values",
          64'({imem_we, imem_addr, imem_wdata, cpu_reset, busy, load_done, load_error}),
          64'({1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}));
    exp_q.delete();
    wr_cnt = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // byte i of the image sits at bytes[8*i +: 8]; with the checksum build the running
  // XOR (optionally corrupted by csum_flip) is inserted after byte csum_after.
  task automatic send_image(input logic [79:0] bytes, input int nbytes, input int bad_stop,
                            input int csum_after, input logic [7:0] csum_flip);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = bytes[8*i +: 8];
      send_byte(b, (i != bad_stop));
      cs = cs ^ b;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (i == csum_after) send_byte(cs ^ csum_flip, 1'b1);
`else
      if (i == csum_after) cs = cs ^ csum_flip;
`endif
    end
    repeat (4 * CPB) @(negedge clock);
  endtask

  typedef struct packed {
    int          nbytes;
    logic [79:0] bytes;
    int          bad_stop;
    int          csum_after;
    int          nwr;
    logic [79:0] wr;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t  vecs[5];
  string vnames[5];

  function automatic vec_t mk(input int nb, input logic [79:0] by, input int bs, input int ca,
                              input int nw, input logic [79:0] wr, input logic d, input logic e);
    vec_t v;
    v.nbytes = nb; v.bytes = by; v.bad_stop = bs; v.csum_after = ca;
    v.nwr = nw; v.wr = wr; v.exp_done = d; v.exp_err = e;
    return v;
  endfunction

  initial begin
    reset   = 1'b0;
    uart_rx = 1'b1;

    vecs[0] = mk(10, 80'hF8_00_00_41_8B_02_00_20_00_02, -1, 9, 2,
                 {40'h01_F8000041, 40'h00_8B020020}, 1'b1, 1'b0);
    vnames[0] = "two_words";
    vecs[1] = mk(2, 80'h00_00, -1, 1, 0, 80'h0, 1'b1, 1'b0);
    vnames[1] = "zero_len";
    vecs[2] = mk(6, 80'h44_33_22_11_01_01, -1, -1, 0, 80'h0, 1'b0, 1'b1);
    vnames[2] = "len_too_big";
    vecs[3] = mk(6, 80'hDD_CC_BB_AA_00_01, 2, -1, 0, 80'h0, 1'b0, 1'b1);
    vnames[3] = "bad_stop";
    vecs[4] = mk(8, 80'h66_55_DE_AD_BE_EF_00_01, -1, 5, 1,
                 {40'h0, 40'h00_DEADBEEF}, 1'b1, 1'b0);
    vnames[4] = "one_word_extra";

    for (int k = 0; k < 5; k++) begin
      do_reset();
      for (int w = 0; w < vecs[k].nwr; w++) exp_q.push_back(vecs[k].wr[40*w +: 40]);
      send_image(vecs[k].bytes, vecs[k].nbytes, vecs[k].bad_stop, vecs[k].csum_after, 8'h00);
      check({vnames[k], "_done"}, 64'(load_done), 64'(vecs[k].exp_done));
      check({vnames[k], "_error"}, 64'(load_error), 64'(vecs[k].exp_err));
      check({vnames[k], "_cpu_reset"}, 64'(cpu_reset), 64'(!vecs[k].exp_done));
      check({vnames[k], "_busy"}, 64'(busy), 64'd0);
      check({vnames[k], "_writes"}, 64'(wr_cnt), 64'(vecs[k].nwr));
      check({vnames[k], "_pending"}, 64'(exp_q.size()), 64'd0);
      if (k == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("done_after_write", 64'(done_cyc > last_wr_cyc), 64'd1);
`else
        check("done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);
`endif
        check("release_with_done", 64'(rel_cyc), 64'(done_cyc));
      end
    end

    // short low glitch while idle is rejected, then a real image loads
    do_reset();
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clock);
    check("glitch_no_write", 64'(wr_cnt), 64'd0);
    check("glitch_flags", 64'({load_done, load_error, cpu_reset}), 64'(3'b001));
    exp_q.push_back({8'h00, 32'h12345678});
    send_image(80'h12_34_56_78_00_01, 6, -1, 5, 8'h00);
    check("glitch_then_load", 64'({load_done, load_error, cpu_reset}), 64'(3'b100));
    check("glitch_then_writes", 64'(wr_cnt), 64'd1);

    // reset after five bytes of a two-word image, then a full reload
    do_reset();
    send_image(80'h8B_02_00_20_00_02, 5, -1, -1, 8'h00);
    check("midload_busy", 64'(busy), 64'd1);
    check("midload_no_write", 64'(wr_cnt), 64'd0);
    do_reset();
    exp_q.push_back({8'h00, 32'h8B020020});
    exp_q.push_back({8'h01, 32'hF8000041});
    send_image(80'hF8_00_00_41_8B_02_00_20_00_02, 10, -1, 9, 8'h00);
    check("reload_done", 64'({load_done, load_error, cpu_reset}), 64'(3'b100));
    check("reload_pending", 64'(exp_q.size()), 64'd0);
    check("reload_final_addr", 64'(imem_addr), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back({8'h00, 32'h8B020020});
    exp_q.push_back({8'h01, 32'hF8000041});
    send_image(80'hF8_00_00_41_8B_02_00_20_00_02, 10, -1, 9, 8'h5A);
    check("bad_csum", 64'({load_done, load_error, cpu_reset}), 64'(3'b011));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
